// File: rtl/rr_index_encoder.sv
// Round-robin priority encoder: picks the first requester at or after the
// rotating pointer and presents its index/one-hot under a valid/ready handshake.
module rr_index_encoder #(
  parameter int NUM_INPUTS = 5,
  localparam int IDX_W = $clog2(NUM_INPUTS)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [NUM_INPUTS-1:0] i_request,
  input  logic                  i_ready,
  output logic                  o_valid,
  output logic [IDX_W-1:0]      o_index,
  output logic [NUM_INPUTS-1:0] o_onehot,
  output logic [IDX_W-1:0]      o_pointer
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      index_q, index_d;
  logic [NUM_INPUTS-1:0] onehot_q, onehot_d;
  logic [IDX_W-1:0]      pointer_q, pointer_d;

  logic                  found;
  logic [IDX_W-1:0]      win_idx;
  logic [IDX_W:0]        cand;
  logic                  load;

  // Rotated scan: distance i from the pointer maps to source (pointer + i) mod N.
  // The !found guard keeps farther (possibly unknown) requests out of the result.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      cand = {1'b0, pointer_q} + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(NUM_INPUTS)) begin
        cand = cand - (IDX_W+1)'(NUM_INPUTS);
      end
      if (!found && i_request[cand[IDX_W-1:0]]) begin
        found   = 1'b1;
        win_idx = cand[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    index_d   = index_q;
    onehot_d  = onehot_q;
    pointer_d = pointer_q;
    load      = (state_q == IDLE) || i_ready;
    if (load) begin
      if (found) begin
        state_d  = GRANT;
        index_d  = win_idx;
        onehot_d = NUM_INPUTS'(1) << win_idx;
        // Wrap at NUM_INPUTS, not at the power of two above it.
        if (win_idx == IDX_W'(NUM_INPUTS - 1)) begin
          pointer_d = '0;
        end else begin
          pointer_d = win_idx + IDX_W'(1);
        end
      end else begin
        state_d  = IDLE;
        index_d  = '0;
        onehot_d = '0;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= IDLE;
      index_q   <= '0;
      onehot_q  <= '0;
      pointer_q <= '0;
    end else begin
      state_q   <= state_d;
      index_q   <= index_d;
      onehot_q  <= onehot_d;
      pointer_q <= pointer_d;
    end
  end

  assign o_valid   = (state_q == GRANT);
  assign o_index   = index_q;
  assign o_onehot  = onehot_q;
  assign o_pointer = pointer_q;

endmodule
